multi_switch_debouncer: RTL and testbench

//  Parametrised N-channel debouncer for mechanical switches and buttons, with clean-level and edge-pulse outputs.

---
 rtl/multi_switch_debouncer.sv | 80 ++++++++
 tb/tb_multi_switch_debouncer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_switch_debouncer.sv
// N-channel switch debouncer: per-channel 2-flop synchroniser and stability counter,
// driving a registered clean level plus one-cycle rise/fall pulses.
module multi_switch_debouncer #(
   parameter int unsigned CHANNELS     = 4,
   parameter int unsigned STABLE_COUNT = 8,
   parameter bit          FAST_RELEASE = 1'b0
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                ce_i,
   input  logic [CHANNELS-1:0] raw_i,
   output logic [CHANNELS-1:0] clean_o,
   output logic [CHANNELS-1:0] rise_o,
   output logic [CHANNELS-1:0] fall_o,
   output logic [CHANNELS-1:0] busy_o,
   output logic                any_change_o
);

   localparam int unsigned     CntW   = $clog2(STABLE_COUNT);
   localparam logic [CntW-1:0] CntMax = CntW'(STABLE_COUNT - 1);

   logic [CHANNELS-1:0] s1_q, s2_q;
   logic [CHANNELS-1:0] clean_q, clean_d;
   logic [CHANNELS-1:0] rise_q, rise_d;
   logic [CHANNELS-1:0] fall_q, fall_d;
   logic [CntW-1:0]     cnt_q [CHANNELS];
   logic [CntW-1:0]     cnt_d [CHANNELS];

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         s1_q    <= '0;
         s2_q    <= '0;
         clean_q <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
         cnt_q   <= '{default: '0};
      end else begin
         s1_q    <= raw_i;
         s2_q    <= s1_q;
         clean_q <= clean_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      clean_d = clean_q;
      rise_d  = '0;
      fall_d  = '0;
      cnt_d   = cnt_q;
      busy_o  = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         busy_o[i] = (cnt_q[i] != '0);
         // A matching sample discards any partial count, so bounce restarts qualification.
         if (s2_q[i] == clean_q[i]) begin
            cnt_d[i] = '0;
         end else if (FAST_RELEASE && clean_q[i]) begin
            clean_d[i] = 1'b0;
            fall_d[i]  = 1'b1;
            cnt_d[i]   = '0;
         end else if (ce_i) begin
            if (cnt_q[i] == CntMax) begin
               clean_d[i] = s2_q[i];
               rise_d[i]  = s2_q[i];
               fall_d[i]  = ~s2_q[i];
               cnt_d[i]   = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   assign clean_o      = clean_q;
   assign rise_o       = rise_q;
   assign fall_o       = fall_q;
   assign any_change_o = |(rise_q | fall_q);

endmodule

// File: tb/tb_multi_switch_debouncer.sv
// Bench for multi_switch_debouncer: a standard instance and a fast-release instance; expected
// clean-edge events are queued as stimulus is applied and matched when pulses appear.
module tb_multi_switch_debouncer;

   typedef struct {
      bit         fr;
      int         cyc;
      logic [3:0] clean;
      logic [3:0] rise;
      logic [3:0] fall;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ce;
   logic [3:0] raw, raw_fr;
   logic [3:0] clean, rise, fall, busy;
   logic [3:0] clean_fr, rise_fr, fall_fr, busy_fr;
   logic       any_change, any_change_fr;

   int  cyc = 0;
   int  n_checks = 0;
   int  n_fail = 0;
   ev_t sb[$];
   ev_t mon_e;

   multi_switch_debouncer #(.CHANNELS(4), .STABLE_COUNT(8), .FAST_RELEASE(1'b0)) dut (
      .clk_i(clk), .rst_ni(rst_n), .ce_i(ce), .raw_i(raw),
      .clean_o(clean), .rise_o(rise), .fall_o(fall), .busy_o(busy),
      .any_change_o(any_change)
   );

   multi_switch_debouncer #(.CHANNELS(4), .STABLE_COUNT(8), .FAST_RELEASE(1'b1)) dut_fr (
      .clk_i(clk), .rst_ni(rst_n), .ce_i(ce), .raw_i(raw_fr),
      .clean_o(clean_fr), .rise_o(rise_fr), .fall_o(fall_fr), .busy_o(busy_fr),
      .any_change_o(any_change_fr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Every pulse on either instance must match the oldest queued expectation.
   always @(negedge clk) begin
      if ((rise | fall) != 4'b0) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_pulse dut cyc=%0d rise=%b fall=%b", cyc, rise, fall);
         end else begin
            mon_e = sb.pop_front();
            if (mon_e.fr || mon_e.cyc != cyc || rise !== mon_e.rise || fall !== mon_e.fall ||
                clean !== mon_e.clean || any_change !== 1'b1) begin
               n_fail++;
               $display("FAIL event dut: got cyc=%0d rise=%b fall=%b clean=%b any=%b; expected fr=%0d cyc=%0d rise=%b fall=%b clean=%b any=1",
                        cyc, rise, fall, clean, any_change, mon_e.fr, mon_e.cyc, mon_e.rise,
                        mon_e.fall, mon_e.clean);
            end
         end
      end
      if ((rise_fr | fall_fr) != 4'b0) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_pulse dut_fr cyc=%0d rise=%b fall=%b", cyc, rise_fr, fall_fr);
         end else begin
            mon_e = sb.pop_front();
            if (!mon_e.fr || mon_e.cyc != cyc || rise_fr !== mon_e.rise ||
                fall_fr !== mon_e.fall || clean_fr !== mon_e.clean || any_change_fr !== 1'b1) begin
               n_fail++;
               $display("FAIL event dut_fr: got cyc=%0d rise=%b fall=%b clean=%b any=%b; expected fr=%0d cyc=%0d rise=%b fall=%b clean=%b any=1",
                        cyc, rise_fr, fall_fr, clean_fr, any_change_fr, mon_e.fr, mon_e.cyc,
                        mon_e.rise, mon_e.fall, mon_e.clean);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input bit fr, input int at, input logic [3:0] cl, input logic [3:0] r,
                       input logic [3:0] f);
      ev_t e;
      e.fr = fr; e.cyc = at; e.clean = cl; e.rise = r; e.fall = f;
      sb.push_back(e);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ce = 1'b1; raw = 4'b0; raw_fr = 4'b0;
      step(3);
      @(negedge clk);
      n_checks++;
      if ({clean, rise, fall, busy, any_change} !== 17'b0) begin
         n_fail++;
         $display("FAIL reset_dut: got clean=%b rise=%b fall=%b busy=%b any=%b, expected all 0",
                  clean, rise, fall, busy, any_change);
      end
      n_checks++;
      if ({clean_fr, rise_fr, fall_fr, busy_fr, any_change_fr} !== 17'b0) begin
         n_fail++;
         $display("FAIL reset_dut_fr: got clean=%b rise=%b fall=%b busy=%b any=%b, expected all 0",
                  clean_fr, rise_fr, fall_fr, busy_fr, any_change_fr);
      end
      step(1);
      rst_n = 1'b1;
      step(2);
   endtask

   task automatic test_single_press();
      raw = 4'b0001;
      push(1'b0, cyc + 10, 4'b0001, 4'b0001, 4'b0000);
      for (int k = 1; k <= 12; k++) begin
         step(1);
         @(negedge clk);
         n_checks++;
         if (busy !== {3'b000, (k >= 3 && k <= 9)}) begin
            n_fail++;
            $display("FAIL press_busy edge %0d: got %b expected %b", k, busy,
                     {3'b000, (k >= 3 && k <= 9)});
         end
      end
      step(1);
      n_checks++;
      if (clean !== 4'b0001 || sb.size() != 0) begin
         n_fail++;
         $display("FAIL press_final: got clean=%b pending=%0d expected clean=0001 pending=0",
                  clean, sb.size());
      end
   endtask

   task automatic test_bounce();
      raw[1] = 1'b1;
      step(5);
      raw[1] = 1'b0;
      step(1);
      raw[1] = 1'b1;
      push(1'b0, cyc + 10, 4'b0011, 4'b0010, 4'b0000);
      step(1);
      @(negedge clk);
      n_checks++;
      if (busy[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL bounce_busy_before_clear: got %b expected 1", busy[1]);
      end
      step(1);
      @(negedge clk);
      n_checks++;
      if (busy[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL bounce_busy_cleared: got %b expected 0", busy[1]);
      end
      step(18);
      n_checks++;
      if (clean !== 4'b0011 || sb.size() != 0) begin
         n_fail++;
         $display("FAIL bounce_final: got clean=%b pending=%0d expected clean=0011 pending=0",
                  clean, sb.size());
      end
   endtask

   task automatic test_short_release();
      raw[2] = 1'b1;
      push(1'b0, cyc + 10, 4'b0111, 4'b0100, 4'b0000);
      step(12);
      raw[2] = 1'b0;
      step(7);
      raw[2] = 1'b1;
      step(15);
      n_checks++;
      if (clean !== 4'b0111 || sb.size() != 0) begin
         n_fail++;
         $display("FAIL short_release_hold: got clean=%b pending=%0d expected clean=0111 pending=0",
                  clean, sb.size());
      end
      raw[2] = 1'b0;
      push(1'b0, cyc + 10, 4'b0011, 4'b0000, 4'b0100);
      step(12);
      n_checks++;
      if (clean !== 4'b0011 || sb.size() != 0) begin
         n_fail++;
         $display("FAIL long_release: got clean=%b pending=%0d expected clean=0011 pending=0",
                  clean, sb.size());
      end
   endtask

   task automatic test_fast_release();
      raw_fr[3] = 1'b1;
      push(1'b1, cyc + 10, 4'b1000, 4'b1000, 4'b0000);
      step(12);
      raw_fr[3] = 1'b0;
      push(1'b1, cyc + 3, 4'b0000, 4'b0000, 4'b1000);
      step(2);
      @(negedge clk);
      n_checks++;
      if (clean_fr[3] !== 1'b1) begin
         n_fail++;
         $display("FAIL fast_release_early: got %b expected 1 after edge 2", clean_fr[3]);
      end
      step(1);
      @(negedge clk);
      n_checks++;
      if (clean_fr[3] !== 1'b0) begin
         n_fail++;
         $display("FAIL fast_release_edge3: got %b expected 0", clean_fr[3]);
      end
      step(2);
      raw_fr[3] = 1'b1;
      push(1'b1, cyc + 10, 4'b1000, 4'b1000, 4'b0000);
      step(12);
      raw_fr[3] = 1'b0;
      push(1'b1, cyc + 3, 4'b0000, 4'b0000, 4'b1000);
      step(5);
      n_checks++;
      if (clean_fr !== 4'b0000 || sb.size() != 0) begin
         n_fail++;
         $display("FAIL fast_release_final: got clean=%b pending=%0d expected clean=0000 pending=0",
                  clean_fr, sb.size());
      end
   endtask

   task automatic test_ce_prescale();
      logic [3:0] bexp;
      raw[0] = 1'b0;
      push(1'b0, cyc + 10, 4'b0010, 4'b0000, 4'b0001);
      step(12);
      raw[0] = 1'b1;
      // Qualified edges: 4, 8, 12, then a ce=0 stretch, then 28..44; terminal at 44.
      push(1'b0, cyc + 44, 4'b0011, 4'b0001, 4'b0000);
      for (int e = 1; e <= 46; e++) begin
         ce = (e % 4 == 0) && !(e > 12 && e < 28);
         step(1);
         @(negedge clk);
         if (e == 3 || e == 4 || e == 20 || e == 43 || e == 44) begin
            bexp = {3'b000, (e == 4 || e == 20 || e == 43)};
            n_checks++;
            if (busy !== bexp) begin
               n_fail++;
               $display("FAIL ce_busy edge %0d: got %b expected %b", e, busy, bexp);
            end
         end
      end
      ce = 1'b1;
      step(2);
      n_checks++;
      if (clean !== 4'b0011 || sb.size() != 0) begin
         n_fail++;
         $display("FAIL ce_final: got clean=%b pending=%0d expected clean=0011 pending=0",
                  clean, sb.size());
      end
   endtask

   task automatic test_reset_mid();
      raw = 4'b0000;
      push(1'b0, cyc + 10, 4'b0000, 4'b0000, 4'b0011);
      step(12);
      raw = 4'b1111;
      step(5);
      @(negedge clk);
      n_checks++;
      if (busy !== 4'b1111) begin
         n_fail++;
         $display("FAIL mid_busy_before_reset: got %b expected 1111", busy);
      end
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      push(1'b0, cyc + 10, 4'b1111, 4'b1111, 4'b0000);
      @(negedge clk);
      n_checks++;
      if ({clean, rise, fall, busy, any_change} !== 17'b0) begin
         n_fail++;
         $display("FAIL mid_reset: got clean=%b rise=%b fall=%b busy=%b any=%b, expected all 0",
                  clean, rise, fall, busy, any_change);
      end
      step(12);
      n_checks++;
      if (clean !== 4'b1111 || sb.size() != 0) begin
         n_fail++;
         $display("FAIL mid_requalify: got clean=%b pending=%0d expected clean=1111 pending=0",
                  clean, sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_bounce();
      test_short_release();
      test_fast_release();
      test_ce_prescale();
      test_reset_mid();
      step(3);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
